// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the two-requester SRAM port arbiter.
// Optional abort-on-timeout is enabled by defining SRAM_ARB_TIMEOUT_EN.
package sram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RESP,
    ARB_HOLD
  } arb_state_t;

  localparam int unsigned ARB_NUM_REQ = 2;

  // Winner index among issuing requesters; prio names the favoured one on a tie.
  function automatic logic rr_pick(input logic [ARB_NUM_REQ-1:0] issuing,
                                   input logic                   prio);
    if (&issuing) return prio;
    return issuing[1] & ~issuing[0];
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester and SRAM-side signals of the SRAM port arbiter.
// slave = arbiter view, master = requesters/SRAM environment view.
interface sram_port_arbiter_if #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned WDATA_W = 16,
  parameter int unsigned RDATA_W = 8
);

  logic               req0_re;
  logic               req0_we;
  logic [ADDR_W-1:0]  req0_addr;
  logic [WDATA_W-1:0] req0_wdata;
  logic [RDATA_W-1:0] req0_rdata;
  logic               req0_resp;
  logic               req0_err;

  logic               req1_re;
  logic               req1_we;
  logic [ADDR_W-1:0]  req1_addr;
  logic [WDATA_W-1:0] req1_wdata;
  logic [RDATA_W-1:0] req1_rdata;
  logic               req1_resp;
  logic               req1_err;

  logic               sram_re;
  logic               sram_we;
  logic [ADDR_W-1:0]  sram_addr;
  logic [WDATA_W-1:0] sram_wdata;
  logic [RDATA_W-1:0] sram_rdata;
  logic               sram_resp;

  logic               grant;

  modport slave (
    input  req0_re, req0_we, req0_addr, req0_wdata,
    output req0_rdata, req0_resp, req0_err,
    input  req1_re, req1_we, req1_addr, req1_wdata,
    output req1_rdata, req1_resp, req1_err,
    output sram_re, sram_we, sram_addr, sram_wdata,
    input  sram_rdata, sram_resp,
    output grant
  );

  modport master (
    output req0_re, req0_we, req0_addr, req0_wdata,
    input  req0_rdata, req0_resp, req0_err,
    output req1_re, req1_we, req1_addr, req1_wdata,
    input  req1_rdata, req1_resp, req1_err,
    input  sram_re, sram_we, sram_addr, sram_wdata,
    output sram_rdata, sram_resp,
    input  grant
  );

endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between two requesters.
// Define SRAM_ARB_TIMEOUT_EN to abort accesses that see no sram_resp within TIMEOUT_CYC.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned WDATA_W     = 16,
  parameter int unsigned RDATA_W     = 8,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                reset,
  sram_port_arbiter_if.slave  bus
);

  arb_state_t state_q, state_d;

  logic               grant_q;
  logic               prio_q;
  logic               sram_re_q;
  logic               sram_we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [WDATA_W-1:0] wdata_q;
  logic [RDATA_W-1:0] rdata0_q;
  logic [RDATA_W-1:0] rdata1_q;
  logic               err_q;

  logic [ARB_NUM_REQ-1:0] issuing;
  logic                   winner;
  logic                   win_we;
  logic [ADDR_W-1:0]      win_addr;
  logic [WDATA_W-1:0]     win_wdata;
  logic                   timeout;
  logic                   resp_pulse;

  always_comb begin
    issuing   = {bus.req1_re | bus.req1_we, bus.req0_re | bus.req0_we};
    winner    = rr_pick(issuing, prio_q);
    win_we    = winner ? bus.req1_we    : bus.req0_we;
    win_addr  = winner ? bus.req1_addr  : bus.req0_addr;
    win_wdata = winner ? bus.req1_wdata : bus.req0_wdata;
  end

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Held at zero outside BUSY, so it starts from zero on every entry to BUSY.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == ARB_BUSY) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  always_comb begin
    timeout = (state_q == ARB_BUSY) && !bus.sram_resp &&
              (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  end
`else
  always_comb begin
    timeout = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (|issuing) state_d = ARB_BUSY;
      ARB_BUSY: if (bus.sram_resp || timeout) state_d = ARB_RESP;
      ARB_RESP: state_d = ARB_HOLD;
      ARB_HOLD: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q   <= 1'b0;
      prio_q    <= 1'b0;
      sram_re_q <= 1'b0;
      sram_we_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|issuing) begin
            grant_q   <= winner;
            addr_q    <= win_addr;
            wdata_q   <= win_wdata;
            // A simultaneous re+we is a write; re only matters when we is low.
            sram_we_q <= win_we;
            sram_re_q <= ~win_we;
          end
        end
        ARB_BUSY: begin
          if (bus.sram_resp) begin
            if (grant_q) rdata1_q <= bus.sram_rdata;
            else         rdata0_q <= bus.sram_rdata;
            err_q     <= 1'b0;
            sram_re_q <= 1'b0;
            sram_we_q <= 1'b0;
          end else if (timeout) begin
            if (grant_q) rdata1_q <= '0;
            else         rdata0_q <= '0;
            err_q     <= 1'b1;
            sram_re_q <= 1'b0;
            sram_we_q <= 1'b0;
          end
        end
        ARB_HOLD: prio_q <= ~grant_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    resp_pulse     = (state_q == ARB_RESP);
    bus.req0_resp  = resp_pulse & ~grant_q;
    bus.req1_resp  = resp_pulse &  grant_q;
    bus.req0_err   = bus.req0_resp & err_q;
    bus.req1_err   = bus.req1_resp & err_q;
    bus.req0_rdata = rdata0_q;
    bus.req1_rdata = rdata1_q;
    bus.sram_re    = sram_re_q;
    bus.sram_we    = sram_we_q;
    bus.sram_addr  = addr_q;
    bus.sram_wdata = wdata_q;
    bus.grant      = grant_q;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized self-checking bench for sram_port_arbiter against a transaction-level model.
// Define SRAM_ARB_TIMEOUT_EN at build time to also exercise the timeout abort.
module tb_sram_port_arbiter;
  import sram_port_arbiter_pkg::*;

  localparam int unsigned AW = 14;
  localparam int unsigned WW = 16;
  localparam int unsigned RW = 8;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_W(AW), .WDATA_W(WW), .RDATA_W(RW)) bus();

  sram_port_arbiter #(
    .ADDR_W(AW), .WDATA_W(WW), .RDATA_W(RW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Requester intent: held until its response pulse.
  bit          pend   [2];
  bit          rq_re  [2];
  bit          rq_we  [2];
  logic [AW-1:0] rq_addr  [2];
  logic [WW-1:0] rq_wdata [2];
  int          last_grant;
  bit          after_txn;
  int          resp_cnt [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply();
    bus.req0_re    = pend[0] & rq_re[0];
    bus.req0_we    = pend[0] & rq_we[0];
    bus.req0_addr  = rq_addr[0];
    bus.req0_wdata = rq_wdata[0];
    bus.req1_re    = pend[1] & rq_re[1];
    bus.req1_we    = pend[1] & rq_we[1];
    bus.req1_addr  = rq_addr[1];
    bus.req1_wdata = rq_wdata[1];
  endtask

  // op: 0 read, 1 write, 2 read+write (treated as write)
  task automatic new_req(input int r, input int op,
                         input logic [AW-1:0] a, input logic [WW-1:0] d);
    pend[r]     = 1'b1;
    rq_re[r]    = (op != 1);
    rq_we[r]    = (op != 0);
    rq_addr[r]  = a;
    rq_wdata[r] = d;
    apply();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    apply();
    bus.sram_resp  = 1'b0;
    bus.sram_rdata = '0;
    step();
    step();
    check("rst_strobes_grant", {bus.sram_re, bus.sram_we, bus.grant}, 0);
    check("rst_addr_wdata", {bus.sram_addr, bus.sram_wdata}, 0);
    check("rst_resp_err", {bus.req0_resp, bus.req1_resp, bus.req0_err, bus.req1_err}, 0);
    check("rst_rdata", {bus.req0_rdata, bus.req1_rdata}, 0);
    reset      = 1'b0;
    last_grant = 1;
    after_txn  = 1'b0;
    resp_cnt[0] = 0;
    resp_cnt[1] = 0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      bus.sram_resp  = 1'($urandom_range(0, 1));
      bus.sram_rdata = RW'($urandom);
      step();
      bus.sram_resp = 1'b0;
      check("idle_quiet", {bus.req1_resp, bus.req0_resp, bus.sram_re, bus.sram_we}, 0);
    end
    after_txn = 1'b0;
  endtask

  // One full access: expected winner from the round-robin rule, SRAM answers after lat cycles.
  task automatic serve(input int unsigned lat, input logic [RW-1:0] rd, output int w);
    int exp_w;
    int n;
    int exp_n;
    bit ewe;
    if (pend[0] && pend[1]) exp_w = (last_grant == 0) ? 1 : 0;
    else                    exp_w = pend[0] ? 0 : 1;
    exp_n = after_txn ? 2 : 1;
    ewe   = rq_we[exp_w];
    w     = exp_w;

    n = 0;
    do begin
      step();
      n++;
    end while (!(bus.sram_re || bus.sram_we) && n < 5);
    check("strobe_latency", n, exp_n);
    check("grant", bus.grant, exp_w);
    check("strobes", {bus.sram_re, bus.sram_we}, {~ewe, ewe});
    check("sram_addr", bus.sram_addr, rq_addr[exp_w]);
    check("sram_wdata", bus.sram_wdata, rq_wdata[exp_w]);

    for (int unsigned k = 0; k < lat; k++) begin
      step();
      check("busy_hold", {bus.sram_re, bus.sram_we, bus.sram_addr, bus.sram_wdata},
            {~ewe, ewe, rq_addr[exp_w], rq_wdata[exp_w]});
      check("busy_no_resp", {bus.req1_resp, bus.req0_resp}, 0);
    end

    bus.sram_resp  = 1'b1;
    bus.sram_rdata = rd;
    step();
    bus.sram_resp  = 1'b0;
    bus.sram_rdata = RW'($urandom);
    check("resp_pulse", {bus.req1_resp, bus.req0_resp}, (exp_w == 1) ? 2'b10 : 2'b01);
    check("resp_err", {bus.req1_err, bus.req0_err}, 0);
    if (!ewe) check("rdata", (exp_w == 1) ? bus.req1_rdata : bus.req0_rdata, rd);
    check("strobe_drop", {bus.sram_re, bus.sram_we}, 0);

    resp_cnt[exp_w]++;
    last_grant   = exp_w;
    pend[exp_w]  = 1'b0;
    apply();
    step();
    check("hold_quiet", {bus.req1_resp, bus.req0_resp, bus.sram_re, bus.sram_we}, 0);
    after_txn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    int n;
    reset = 1'b1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    rq_re[0] = 1'b0; rq_re[1] = 1'b0;
    rq_we[0] = 1'b0; rq_we[1] = 1'b0;
    rq_addr[0] = '0; rq_addr[1] = '0;
    rq_wdata[0] = '0; rq_wdata[1] = '0;
    apply();
    bus.sram_resp  = 1'b0;
    bus.sram_rdata = '0;

    // Single write, then a single read from the other requester
    do_reset();
    new_req(0, 1, 14'h0010, 16'hBEEF);
    serve(2, 8'h00, w);
    new_req(1, 0, 14'h0020, 16'h0000);
    serve(0, 8'h5A, w);
    check("single_read_owner", w, 1);

    // Simultaneous reads right after reset: req0 first
    do_reset();
    new_req(0, 0, 14'h0100, 16'h0);
    new_req(1, 0, 14'h0200, 16'h0);
    serve(1, 8'h11, w);
    check("simul_first", w, 0);
    serve(1, 8'h22, w);
    check("simul_second", w, 1);

    // Continuous contention: strict alternation
    do_reset();
    new_req(0, $urandom_range(0, 2), AW'($urandom), WW'($urandom));
    new_req(1, $urandom_range(0, 2), AW'($urandom), WW'($urandom));
    for (int i = 0; i < 8; i++) begin
      serve($urandom_range(0, 2), RW'($urandom), w);
      check("contend_grant", w, i % 2);
      new_req(w, $urandom_range(0, 2), AW'($urandom), WW'($urandom));
    end
    check("contend_cnt0", resp_cnt[0], 4);
    check("contend_cnt1", resp_cnt[1], 4);

    // Reset while BUSY abandons the access; req0 wins afterwards
    do_reset();
    new_req(0, 0, 14'h0033, 16'h0);
    new_req(1, 1, 14'h0044, 16'h1234);
    step();
    check("pre_rst_busy", bus.sram_re | bus.sram_we, 1);
    reset = 1'b1;
    step();
    check("rst_abort", {bus.sram_re, bus.sram_we, bus.req1_resp, bus.req0_resp, bus.grant}, 0);
    reset      = 1'b0;
    last_grant = 1;
    after_txn  = 1'b0;
    serve(1, 8'h77, w);
    check("rst_winner", w, 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < 2; r++)
        if (!pend[r] && $urandom_range(0, 1) == 1)
          new_req(r, $urandom_range(0, 2), AW'($urandom), WW'($urandom));
      if (!pend[0] && !pend[1]) begin
        idle($urandom_range(1, 3));
        new_req($urandom_range(0, 1), $urandom_range(0, 2), AW'($urandom), WW'($urandom));
      end
      serve($urandom_range(0, 3), RW'($urandom), w);
    end

`ifdef SRAM_ARB_TIMEOUT_EN
    // Withheld sram_resp: aborted after TO busy cycles with err=1 and rdata=0
    do_reset();
    new_req(0, 0, 14'h0055, 16'h0);
    serve(0, 8'hA5, w);
    new_req(0, 0, 14'h0066, 16'h0);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.sram_re && n < 5);
    check("to_strobe", bus.sram_re, 1);
    n = 0;
    while (!bus.req0_resp && n < 3 * TO) begin
      step();
      n++;
    end
    check("to_cycles", n, TO);
    check("to_err", {bus.req0_resp, bus.req0_err}, 2'b11);
    check("to_rdata", bus.req0_rdata, 0);
    check("to_strobe_drop", {bus.sram_re, bus.sram_we}, 0);
    pend[0] = 1'b0;
    apply();
    step();
    check("to_hold_quiet", {bus.req1_resp, bus.req0_resp, bus.req0_err}, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
